ttt_game_ctrl: RTL and testbench

- Game controller directly downstream of the 4x4 keypad scanner.
- Consumes the scanner's key code and active-low ready flag, and turns each physical key press into exactly one game event.
- Holds the 3x3 tic-tac-toe board, alternates players, and detects win and draw.
- Exposes board and status to the VGA renderer.

---
 rtl/ttt_pkg.sv | 37 +++
 rtl/ttt_key_event.sv | 52 +++++
 rtl/ttt_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared encodings and win-line table for the tic-tac-toe controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WIN   = 2'b10,
        ST_DRAW  = 2'b11
    } game_state_t;

    localparam logic [3:0] KEY_NEW      = 4'd10;
    localparam logic [3:0] KEY_CELL_MIN = 4'd1;
    localparam logic [3:0] KEY_CELL_MAX = 4'd9;

    // Bit c of a mask is cell c (row-major, cell 0 top-left).
    localparam logic [7:0][8:0] WIN_LINES = {
        9'b000_000_111, 9'b000_111_000, 9'b111_000_000,
        9'b001_001_001, 9'b010_010_010, 9'b100_100_100,
        9'b100_010_001, 9'b001_010_100
    };

    function automatic logic [8:0] complete_lines(input logic [8:0] own);
        logic [8:0] acc;
        acc = '0;
        for (int l = 0; l < 8; l++)
            if ((own & WIN_LINES[l]) == WIN_LINES[l])
                acc = acc | WIN_LINES[l];
        return acc;
    endfunction

endpackage

// File: rtl/ttt_key_event.sv
// Synchronizes the scanner flags and turns each physical key press into one event,
// using a release lockout longer than a full scan so row cycling cannot retrigger.
module ttt_key_event #(
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 25000000,
    parameter int CW             = 25
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_ready_n,
    input  logic [3:0] i_key_code,
    output logic       o_evt,
    output logic [3:0] o_evt_key
);

    localparam logic [CW-1:0] REL = CW'(RELEASE_CYCLES);

    logic [SYNC_STAGES-1:0]      r_rdy_sync;
    logic [SYNC_STAGES-1:0][3:0] r_key_sync;
    logic                        r_rdy_prev;
    logic [CW-1:0]               r_cnt;
    logic                        w_rdy;
    logic                        w_armed;

    assign w_rdy     = r_rdy_sync[SYNC_STAGES-1];
    assign w_armed   = (r_cnt == REL);
    assign o_evt     = !w_rdy && r_rdy_prev && w_armed;
    assign o_evt_key = r_key_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdy_sync <= '1;
            r_key_sync <= '0;
            r_rdy_prev <= 1'b1;
            r_cnt      <= REL;
        end else begin
            r_rdy_sync[0] <= i_key_ready_n;
            r_key_sync[0] <= i_key_code;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_rdy_sync[s] <= r_rdy_sync[s-1];
                r_key_sync[s] <= r_key_sync[s-1];
            end
            r_rdy_prev <= w_rdy;
            // Disarmed: count consecutive released cycles, saturating at REL.
            if (o_evt)
                r_cnt <= '0;
            else if (!w_armed)
                r_cnt <= w_rdy ? r_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe controller: holds the board, alternates players, and resolves
// win/draw one cycle after each accepted move.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 25000000,
    parameter int CW             = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_key_ready_n,
    input  logic [3:0]  i_key_code,
    output logic [17:0] o_board,
    output logic        o_turn,
    output logic [1:0]  o_game_state,
    output logic [1:0]  o_winner,
    output logic [8:0]  o_win_line,
    output logic        o_move_pulse,
    output logic        o_illegal_pulse
);

    logic        w_evt;
    logic [3:0]  w_evt_key;

    game_state_t r_state, w_state_nxt;
    logic [17:0] r_board, w_board_nxt;
    logic        r_turn, w_turn_nxt;
    logic [1:0]  r_winner, w_winner_nxt;
    logic [8:0]  r_win_line, w_line_nxt;
    logic [3:0]  r_move_cnt, w_cnt_nxt;
    logic        r_move_pulse, w_move_nxt;
    logic        r_illegal_pulse, w_illegal_nxt;

    cell_t       w_mark;
    logic        w_is_cell;
    logic [8:0]  w_sel;
    logic [8:0]  w_occ;
    logic [8:0]  w_own;
    logic [8:0]  w_hits;

    ttt_key_event #(
        .SYNC_STAGES    (SYNC_STAGES),
        .RELEASE_CYCLES (RELEASE_CYCLES),
        .CW             (CW)
    ) u_key_event (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_key_ready_n (i_key_ready_n),
        .i_key_code    (i_key_code),
        .o_evt         (w_evt),
        .o_evt_key     (w_evt_key)
    );

    assign w_mark    = r_turn ? MARK_O : MARK_X;
    assign w_is_cell = (w_evt_key >= KEY_CELL_MIN) && (w_evt_key <= KEY_CELL_MAX);

    always_comb begin
        w_sel = '0;
        w_occ = '0;
        w_own = '0;
        for (int c = 0; c < 9; c++) begin
            w_sel[c] = (w_evt_key == 4'(c) + KEY_CELL_MIN);
            w_occ[c] = (r_board[2*c +: 2] != EMPTY);
            w_own[c] = (r_board[2*c +: 2] == w_mark);
        end
    end

    // The mover's mark is still r_turn during CHECK, so only its lines matter.
    assign w_hits = complete_lines(w_own);

    always_comb begin
        w_state_nxt   = r_state;
        w_board_nxt   = r_board;
        w_turn_nxt    = r_turn;
        w_winner_nxt  = r_winner;
        w_line_nxt    = r_win_line;
        w_cnt_nxt     = r_move_cnt;
        w_move_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (w_evt && w_evt_key == KEY_NEW) begin
                    w_board_nxt = '0;
                    w_turn_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (w_evt && w_is_cell) begin
                    if (|(w_sel & w_occ)) begin
                        w_illegal_nxt = 1'b1;
                    end else begin
                        for (int c = 0; c < 9; c++)
                            if (w_sel[c])
                                w_board_nxt[2*c +: 2] = w_mark;
                        w_move_nxt  = 1'b1;
                        w_cnt_nxt   = r_move_cnt + 4'd1;
                        w_state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (|w_hits) begin
                    w_state_nxt  = ST_WIN;
                    w_winner_nxt = w_mark;
                    w_line_nxt   = w_hits;
                end else if (r_move_cnt == 4'd9) begin
                    w_state_nxt = ST_DRAW;
                end else begin
                    w_turn_nxt  = ~r_turn;
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_WIN, ST_DRAW: begin
                if (w_evt && w_evt_key == KEY_NEW) begin
                    w_board_nxt  = '0;
                    w_turn_nxt   = 1'b0;
                    w_winner_nxt = '0;
                    w_line_nxt   = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_PLAY;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= ST_PLAY;
            r_board         <= '0;
            r_turn          <= 1'b0;
            r_winner        <= '0;
            r_win_line      <= '0;
            r_move_cnt      <= '0;
            r_move_pulse    <= 1'b0;
            r_illegal_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_board         <= w_board_nxt;
            r_turn          <= w_turn_nxt;
            r_winner        <= w_winner_nxt;
            r_win_line      <= w_line_nxt;
            r_move_cnt      <= w_cnt_nxt;
            r_move_pulse    <= w_move_nxt;
            r_illegal_pulse <= w_illegal_nxt;
        end
    end

    assign o_board         = r_board;
    assign o_turn          = r_turn;
    assign o_game_state    = r_state;
    assign o_winner        = r_winner;
    assign o_win_line      = r_win_line;
    assign o_move_pulse    = r_move_pulse;
    assign o_illegal_pulse = r_illegal_pulse;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: expected move/illegal events are queued as keys
// are pressed and matched against pulses seen by a monitor.
module tb_ttt_game_ctrl;

    localparam int REL = 64;

    typedef struct packed {
        logic        mv;
        logic [17:0] board;
        logic [1:0]  st;
        logic        turn;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy_n = 1'b1;
    logic [3:0]  key = 4'd0;
    logic [17:0] o_board;
    logic        o_turn;
    logic [1:0]  o_game_state;
    logic [1:0]  o_winner;
    logic [8:0]  o_win_line;
    logic        o_move_pulse;
    logic        o_illegal_pulse;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         mon_e;
    logic [17:0] m_board = '0;
    logic        m_turn = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl #(.SYNC_STAGES(2), .RELEASE_CYCLES(REL), .CW(7)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_key_ready_n   (rdy_n),
        .i_key_code      (key),
        .o_board         (o_board),
        .o_turn          (o_turn),
        .o_game_state    (o_game_state),
        .o_winner        (o_winner),
        .o_win_line      (o_win_line),
        .o_move_pulse    (o_move_pulse),
        .o_illegal_pulse (o_illegal_pulse)
    );

    // Every cycle a pulse is high yields one observed event, so stuck pulses show up as extras.
    always @(negedge clk) begin
        if (o_move_pulse) begin
            mon_e = '{mv: 1'b1, board: o_board, st: o_game_state, turn: o_turn};
            obs_q.push_back(mon_e);
        end
        if (o_illegal_pulse) begin
            mon_e = '{mv: 1'b0, board: o_board, st: o_game_state, turn: o_turn};
            obs_q.push_back(mon_e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Game model: queue what a key should produce when the controller is in PLAY.
    task automatic exp_key(input int k);
        ev_t e;
        if (k == 10) begin
            m_board = '0;
            m_turn  = 1'b0;
        end else if (m_board[2*(k-1) +: 2] == 2'b00) begin
            m_board[2*(k-1) +: 2] = m_turn ? 2'b10 : 2'b01;
            e = '{mv: 1'b1, board: m_board, st: 2'b01, turn: m_turn};
            exp_q.push_back(e);
            m_turn = ~m_turn;
        end else begin
            e = '{mv: 1'b0, board: m_board, st: 2'b00, turn: m_turn};
            exp_q.push_back(e);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel, input bit toggle);
        key = k;
        tick(1);
        rdy_n = 1'b0;
        for (int c = 0; c < hold; c++) begin
            if (toggle && (c % 200) == 100) begin
                rdy_n = 1'b1;
                tick(3);
                rdy_n = 1'b0;
            end
            tick(1);
        end
        rdy_n = 1'b1;
        tick(rel);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy_n = 1'b1; key = 4'd0;
        tick(3);
        rst = 1'b0;
        tick(100);
        n_cmp++; if (o_board !== 18'd0) begin n_bad++; $display("FAIL reset_board: got %h want 0", o_board); end
        n_cmp++; if (o_turn !== 1'b0) begin n_bad++; $display("FAIL reset_turn: got %b want 0", o_turn); end
        n_cmp++; if (o_game_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", o_game_state); end
        n_cmp++; if (o_winner !== 2'b00) begin n_bad++; $display("FAIL reset_winner: got %b want 00", o_winner); end
        n_cmp++; if (o_win_line !== 9'd0) begin n_bad++; $display("FAIL reset_winline: got %b want 0", o_win_line); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_single_press();
        ev_t eo, ee;
        exp_key(5);
        press(4'd5, 1000, REL + 10, 1'b1);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL single_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (o_board[9:8] !== 2'b01) begin n_bad++; $display("FAIL single_cell4: got %b want 01", o_board[9:8]); end
        n_cmp++; if (o_turn !== 1'b1) begin n_bad++; $display("FAIL single_turn: got %b want 1", o_turn); end
        n_cmp++; if (o_game_state !== 2'b00) begin n_bad++; $display("FAIL single_state: got %b want 00", o_game_state); end
    endtask

    task automatic test_win();
        ev_t eo, ee;
        int seq[5] = '{1, 4, 2, 5, 3};
        press(4'd10, 20, REL + 10, 1'b0);
        exp_key(10);
        foreach (seq[i]) begin
            exp_key(seq[i]);
            press(4'(seq[i]), 20, REL + 10, 1'b0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL win_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL win_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (o_game_state !== 2'b10) begin n_bad++; $display("FAIL win_state: got %b want 10", o_game_state); end
        n_cmp++; if (o_winner !== 2'b01) begin n_bad++; $display("FAIL win_winner: got %b want 01", o_winner); end
        n_cmp++; if (o_win_line !== 9'b000000111) begin n_bad++; $display("FAIL win_line: got %b want 000000111", o_win_line); end
        press(4'd7, 20, REL + 10, 1'b0);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL win_key7_pulses: got %0d want 0", obs_q.size()); end
        n_cmp++; if (o_board !== m_board) begin n_bad++; $display("FAIL win_key7_board: got %h want %h", o_board, m_board); end
        n_cmp++; if (o_game_state !== 2'b10) begin n_bad++; $display("FAIL win_key7_state: got %b want 10", o_game_state); end
        obs_q.delete();
    endtask

    task automatic test_illegal();
        ev_t eo, ee;
        press(4'd10, 20, REL + 10, 1'b0);
        exp_key(10);
        exp_key(5);
        press(4'd5, 20, REL + 10, 1'b0);
        exp_key(5);
        press(4'd5, 20, REL + 10, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL illegal_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL illegal_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (o_board[9:8] !== 2'b01) begin n_bad++; $display("FAIL illegal_cell4: got %b want 01", o_board[9:8]); end
        n_cmp++; if (o_turn !== 1'b1) begin n_bad++; $display("FAIL illegal_turn: got %b want 1", o_turn); end
    endtask

    task automatic test_draw();
        ev_t eo, ee;
        int seq[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        press(4'd10, 20, REL + 10, 1'b0);
        exp_key(10);
        foreach (seq[i]) begin
            exp_key(seq[i]);
            press(4'(seq[i]), 20, REL + 10, 1'b0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL draw_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL draw_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (o_game_state !== 2'b11) begin n_bad++; $display("FAIL draw_state: got %b want 11", o_game_state); end
        n_cmp++; if (o_winner !== 2'b00) begin n_bad++; $display("FAIL draw_winner: got %b want 00", o_winner); end
        n_cmp++; if (o_win_line !== 9'd0) begin n_bad++; $display("FAIL draw_winline: got %b want 0", o_win_line); end
        press(4'd10, 20, REL + 10, 1'b0);
        exp_key(10);
        n_cmp++; if (o_board !== 18'd0) begin n_bad++; $display("FAIL draw_new_board: got %h want 0", o_board); end
        n_cmp++; if (o_turn !== 1'b0) begin n_bad++; $display("FAIL draw_new_turn: got %b want 0", o_turn); end
        n_cmp++; if (o_game_state !== 2'b00) begin n_bad++; $display("FAIL draw_new_state: got %b want 00", o_game_state); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL draw_new_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_lockout();
        ev_t eo, ee;
        exp_key(1);
        press(4'd1, 20, 20, 1'b0);
        press(4'd2, 20, REL + 10, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL lockout_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL lockout_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++; if (o_board !== m_board) begin n_bad++; $display("FAIL lockout_board: got %h want %h", o_board, m_board); end
    endtask

    task automatic test_reset_in_check();
        ev_t eo, ee;
        bit  seen = 1'b0;
        exp_key(9);
        key = 4'd9;
        tick(1);
        rdy_n = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (o_move_pulse === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        rdy_n = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstchk_event: got no move pulse within 20 cycles, want one"); end
        n_cmp++; if (o_board !== 18'd0) begin n_bad++; $display("FAIL rstchk_board: got %h want 0", o_board); end
        n_cmp++; if (o_turn !== 1'b0) begin n_bad++; $display("FAIL rstchk_turn: got %b want 0", o_turn); end
        n_cmp++; if (o_game_state !== 2'b00) begin n_bad++; $display("FAIL rstchk_state: got %b want 00", o_game_state); end
        n_cmp++; if (o_winner !== 2'b00 || o_win_line !== 9'd0) begin n_bad++; $display("FAIL rstchk_winner: got %b/%b want 00/0", o_winner, o_win_line); end
        n_cmp++; if (o_move_pulse !== 1'b0 || o_illegal_pulse !== 1'b0) begin n_bad++; $display("FAIL rstchk_pulses: got %b%b want 00", o_move_pulse, o_illegal_pulse); end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstchk_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL rstchk_event_data: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
        m_board = '0;
        m_turn  = 1'b0;
        tick(3);
        exp_key(1);
        press(4'd1, 20, REL + 10, 1'b0);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rstchk_next_evcount: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            eo = obs_q.pop_front(); ee = exp_q.pop_front(); n_cmp++;
            if (eo !== ee) begin n_bad++; $display("FAIL rstchk_next_event: got %h want %h", eo, ee); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_win();
        test_illegal();
        test_draw();
        test_lockout();
        test_reset_in_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
